// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter from user output ports onto the leaf's single packet link.
// Per-port credit tracks destination freespace; each packet carries a per-port sequence address.
module leaf_out_arbiter #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned NUM_OUT_PORTS         = 4,
  parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dst_port,
  input  logic                                    credit_upd,
  input  logic [NUM_PORT_BITS-1:0]                credit_port,
  input  logic                                    out_stall,
  output logic [PACKET_BITS-1:0]                  dout_packet
);

  localparam int unsigned CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int unsigned PTR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

  logic [PTR_BITS-1:0]      rr_ptr;
  logic [NUM_OUT_PORTS-1:0] cfg_valid;
  logic [NUM_LEAF_BITS-1:0] dst_leaf   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dst_port   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr       [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_nxt [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  din_arr    [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic                     grant_vld;
  logic [PTR_BITS-1:0]      grant_idx;
  logic [PTR_BITS-1:0]      cand;
  logic [31:0]              credit_sum;

  // Unpack user data and decide which ports may be served this cycle.
  always_comb begin
    for (int p = 0; p < NUM_OUT_PORTS; p++) begin
      din_arr[p]  = din_leaf_user2interface[p*PAYLOAD_BITS +: PAYLOAD_BITS];
      eligible[p] = vld_user2interface[p] & cfg_valid[p] & (credit[p] != '0) & ~out_stall;
    end
  end

  // Round-robin search from rr_ptr; walking backwards lets the nearest candidate win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NUM_OUT_PORTS - 1; i >= 0; i--) begin
      cand = PTR_BITS'((32'(rr_ptr) + 32'(i)) % NUM_OUT_PORTS);
      if (eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot accept back to the user in the grant cycle.
  always_comb begin
    for (int p = 0; p < NUM_OUT_PORTS; p++) begin
      ack_interface2user[p] = grant_vld && (grant_idx == PTR_BITS'(p));
    end
  end

  // Credit next value: replenish, consume on grant, then saturate at buffer depth.
  always_comb begin
    credit_sum = '0;
    for (int p = 0; p < NUM_OUT_PORTS; p++) begin
      credit_sum = 32'(credit[p]);
      if (credit_upd && (credit_port == NUM_PORT_BITS'(p)))
        credit_sum = credit_sum + 32'(FREESPACE_UPDATE_SIZE);
      if (ack_interface2user[p])
        credit_sum = credit_sum - 32'd1;
      credit_nxt[p] = (credit_sum > 32'(CREDIT_MAX)) ? CREDIT_MAX : CREDIT_BITS'(credit_sum);
    end
  end

  // Output packet register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_packet <= '0;
      rr_ptr      <= '0;
    end else begin
      if (grant_vld) begin
        dout_packet <= PACKET_BITS'({1'b1, dst_leaf[grant_idx], dst_port[grant_idx],
                                     addr[grant_idx], din_arr[grant_idx]});
        rr_ptr      <= PTR_BITS'((32'(grant_idx) + 32'd1) % NUM_OUT_PORTS);
      end else begin
        dout_packet <= '0;
      end
    end
  end

  // Per-port configuration, sequence address and credit state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_valid <= '0;
      for (int p = 0; p < NUM_OUT_PORTS; p++) begin
        dst_leaf[p] <= '0;
        dst_port[p] <= '0;
        addr[p]     <= '0;
        credit[p]   <= CREDIT_MAX;
      end
    end else begin
      for (int p = 0; p < NUM_OUT_PORTS; p++) begin
        credit[p] <= credit_nxt[p];
        if (ack_interface2user[p])
          addr[p] <= addr[p] + NUM_ADDR_BITS'(1);
        if (cfg_wr && (cfg_port == NUM_PORT_BITS'(p))) begin
          cfg_valid[p] <= 1'b1;
          dst_leaf[p]  <= cfg_dst_leaf;
          dst_port[p]  <= cfg_dst_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_leaf_out_arbiter;

  logic          clk;
  logic          reset;
  logic [127:0]  din;
  logic [3:0]    vld;
  logic [3:0]    ack;
  logic          cfg_wr;
  logic [3:0]    cfg_port;
  logic [4:0]    cfg_dst_leaf;
  logic [3:0]    cfg_dst_port;
  logic          credit_upd;
  logic [3:0]    credit_port;
  logic          out_stall;
  logic [48:0]   dout;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_cfg  [4];
  int m_leaf [4];
  int m_port [4];
  int m_addr [4];
  int m_cred [4];
  int m_rr;

  // Results of the most recent step
  logic [3:0]  ack_got, ack_exp;
  logic [48:0] pkt_got, pkt_exp;
  int          last_g;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr                  (cfg_wr),
    .cfg_port                (cfg_port),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .credit_upd              (credit_upd),
    .credit_port             (credit_port),
    .out_stall               (out_stall),
    .dout_packet             (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_cfg[p] = 1'b0; m_leaf[p] = 0; m_port[p] = 0; m_addr[p] = 0; m_cred[p] = 128;
    end
    m_rr = 0;
  endtask

  task automatic clear_inputs();
    din = '0; vld = '0; cfg_wr = 1'b0; cfg_port = '0; cfg_dst_leaf = '0; cfg_dst_port = '0;
    credit_upd = 1'b0; credit_port = '0; out_stall = 1'b0;
  endtask

  // Advance one clock with current inputs; record DUT and model ack/packet.
  task automatic step();
    int g; int c;
    logic [48:0] pkt_nxt;
    @(negedge clk);
    g = -1;
    if (!out_stall) begin
      for (int k = 0; k < 4; k++) begin
        int p;
        p = (m_rr + k) % 4;
        if (g < 0 && vld[p] && m_cfg[p] && m_cred[p] > 0) g = p;
      end
    end
    ack_exp = (g >= 0) ? 4'(1 << g) : 4'b0;
    ack_got = ack;
    pkt_nxt = '0;
    if (g >= 0)
      pkt_nxt = {1'b1, 5'(m_leaf[g]), 4'(m_port[g]), 7'(m_addr[g]), din[g*32 +: 32]};
    for (int p = 0; p < 4; p++) begin
      c = m_cred[p];
      if (credit_upd && int'(credit_port) == p) c = c + 64;
      if (p == g) c = c - 1;
      m_cred[p] = (c > 128) ? 128 : c;
    end
    if (g >= 0) begin
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_rr = (g + 1) % 4;
    end
    if (cfg_wr && int'(cfg_port) < 4) begin
      m_cfg[cfg_port]  = 1'b1;
      m_leaf[cfg_port] = int'(cfg_dst_leaf);
      m_port[cfg_port] = int'(cfg_dst_port);
    end
    @(posedge clk); #1;
    pkt_got = dout;
    pkt_exp = pkt_nxt;
    last_g  = g;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Write one configuration entry (no comparisons here).
  task automatic configure(input int port, input int leaf, input int dport);
    cfg_wr = 1'b1; cfg_port = 4'(port); cfg_dst_leaf = 5'(leaf); cfg_dst_port = 4'(dport);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_assert++; if (dout !== 49'd0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
    n_assert++; if (ack !== 4'd0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    vld = 4'b1111; din = {4{32'h1234_5678}};
    step();
    n_assert++; if (ack_got !== 4'b0000) begin n_fail++; $display("FAIL reset_unconfigured_ack got=%b exp=0000", ack_got); end
    n_assert++; if (pkt_got !== 49'd0) begin n_fail++; $display("FAIL reset_unconfigured_pkt got=%h exp=0", pkt_got); end
    clear_inputs();
  endtask

  task automatic test_rotation();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_a [5] = '{0, 0, 0, 0, 1};
    logic [48:0] exp_pkt;
    do_reset();
    for (int p = 0; p < 4; p++) configure(p, 5, p);
    vld = 4'b1111;
    for (int p = 0; p < 4; p++) din[p*32 +: 32] = 32'hA0 + 32'(p);
    for (int i = 0; i < 5; i++) begin
      step();
      exp_pkt = {1'b1, 5'd5, 4'(exp_g[i]), 7'(exp_a[i]), 32'hA0 + 32'(exp_g[i])};
      n_assert++; if (ack_got !== 4'(1 << exp_g[i])) begin n_fail++; $display("FAIL rot_ack i=%0d got=%b exp=%b", i, ack_got, 4'(1 << exp_g[i])); end
      n_assert++; if (pkt_got !== exp_pkt) begin n_fail++; $display("FAIL rot_pkt i=%0d got=%h exp=%h", i, pkt_got, exp_pkt); end
    end
    clear_inputs();
  endtask

  task automatic test_unconfigured();
    logic [48:0] exp_pkt;
    do_reset();
    vld = 4'b0100; din[64 +: 32] = 32'hCAFE_0002;
    for (int i = 0; i < 10; i++) begin
      step();
      n_assert++; if (ack_got !== 4'b0000 || pkt_got !== 49'd0) begin n_fail++; $display("FAIL uncfg_idle i=%0d ack=%b pkt=%h exp ack=0000 pkt=0", i, ack_got, pkt_got); end
    end
    configure(2, 9, 3);
    n_assert++; if (ack_got !== 4'b0000 || pkt_got !== 49'd0) begin n_fail++; $display("FAIL uncfg_cfg_cycle ack=%b pkt=%h exp ack=0000 pkt=0", ack_got, pkt_got); end
    step();
    exp_pkt = {1'b1, 5'd9, 4'd3, 7'd0, 32'hCAFE_0002};
    n_assert++; if (ack_got !== 4'b0100) begin n_fail++; $display("FAIL uncfg_first_ack got=%b exp=0100", ack_got); end
    n_assert++; if (pkt_got !== exp_pkt) begin n_fail++; $display("FAIL uncfg_first_pkt got=%h exp=%h", pkt_got, exp_pkt); end
    clear_inputs();
  endtask

  task automatic test_credit();
    int cnt;
    do_reset();
    configure(0, 1, 7);
    vld = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 140; i++) begin
      din[31:0] = 32'(i);
      step();
      if (ack_got != 4'b0) cnt++;
      n_assert++; if (ack_got !== ack_exp || pkt_got !== pkt_exp) begin n_fail++; $display("FAIL credit_drain i=%0d ack=%b/%b pkt=%h/%h (got/exp)", i, ack_got, ack_exp, pkt_got, pkt_exp); end
    end
    n_assert++; if (cnt !== 128) begin n_fail++; $display("FAIL credit_drain_count got=%0d exp=128", cnt); end
    credit_upd = 1'b1; credit_port = 4'd0;
    step();
    credit_upd = 1'b0;
    cnt = (ack_got != 4'b0) ? 1 : 0;
    n_assert++; if (ack_got !== 4'b0000) begin n_fail++; $display("FAIL credit_upd_cycle_ack got=%b exp=0000", ack_got); end
    for (int i = 0; i < 80; i++) begin
      step();
      if (ack_got != 4'b0) cnt++;
      n_assert++; if (ack_got !== ack_exp || pkt_got !== pkt_exp) begin n_fail++; $display("FAIL credit_refill i=%0d ack=%b/%b pkt=%h/%h (got/exp)", i, ack_got, ack_exp, pkt_got, pkt_exp); end
    end
    n_assert++; if (cnt !== 64) begin n_fail++; $display("FAIL credit_refill_count got=%0d exp=64", cnt); end
    clear_inputs();
  endtask

  task automatic test_addr_wrap();
    do_reset();
    configure(1, 2, 0);
    vld = 4'b0010; credit_upd = 1'b1; credit_port = 4'd1;
    for (int i = 0; i < 130; i++) begin
      din[32 +: 32] = $urandom;
      step();
      n_assert++; if (pkt_got[48] !== 1'b1 || pkt_got[38:32] !== 7'(i % 128)) begin n_fail++; $display("FAIL addr_wrap i=%0d got=%0d exp=%0d", i, pkt_got[38:32], i % 128); end
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    for (int p = 0; p < 4; p++) configure(p, 3, p);
    vld = 4'b0001; din = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step();
    n_assert++; if (ack_got !== 4'b0001) begin n_fail++; $display("FAIL stall_prep_ack got=%b exp=0001", ack_got); end
    vld = 4'b0011; out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++; if (ack_got !== 4'b0000 || pkt_got !== 49'd0) begin n_fail++; $display("FAIL stall_hold i=%0d ack=%b pkt=%h exp ack=0000 pkt=0", i, ack_got, pkt_got); end
    end
    out_stall = 1'b0;
    step();
    n_assert++; if (ack_got !== 4'b0010 || pkt_got !== {1'b1, 5'd3, 4'd1, 7'd0, 32'hD1}) begin n_fail++; $display("FAIL stall_resume1 ack=%b pkt=%h exp ack=0010", ack_got, pkt_got); end
    step();
    n_assert++; if (ack_got !== 4'b0001 || pkt_got !== {1'b1, 5'd3, 4'd0, 7'd1, 32'hD0}) begin n_fail++; $display("FAIL stall_resume2 ack=%b pkt=%h exp ack=0001", ack_got, pkt_got); end
    clear_inputs();
  endtask

  task automatic test_saturate();
    int cnt;
    do_reset();
    configure(3, 4, 4);
    vld = 4'b1000; din[96 +: 32] = 32'h5A5A_5A5A;
    credit_upd = 1'b1; credit_port = 4'd3;
    step();
    credit_upd = 1'b0;
    cnt = (ack_got != 4'b0) ? 1 : 0;
    for (int i = 0; i < 139; i++) begin
      step();
      if (ack_got != 4'b0) cnt++;
    end
    n_assert++; if (cnt !== 129) begin n_fail++; $display("FAIL saturate_count got=%0d exp=129", cnt); end
    clear_inputs();
  endtask

  task automatic test_reset_midstream();
    int cnt;
    do_reset();
    for (int p = 0; p < 4; p++) configure(p, 6, p);
    vld = 4'b1111; din = {4{32'hFFFF_0000}};
    for (int i = 0; i < 6; i++) step();
    n_assert++; if (pkt_got[48] !== 1'b1) begin n_fail++; $display("FAIL midreset_busy got=%b exp=1", pkt_got[48]); end
    #2 reset = 1'b1;
    #1;
    n_assert++; if (dout !== 49'd0 || ack !== 4'b0000) begin n_fail++; $display("FAIL midreset_async dout=%h ack=%b exp 0/0000", dout, ack); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    clear_inputs();
    configure(2, 8, 2);
    vld = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 135; i++) begin
      step();
      if (ack_got != 4'b0) cnt++;
    end
    n_assert++; if (cnt !== 128) begin n_fail++; $display("FAIL midreset_credit got=%0d exp=128", cnt); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++) din[p*32 +: 32] = $urandom;
      vld          = 4'($urandom);
      cfg_wr       = ($urandom % 6) == 0;
      cfg_port     = 4'($urandom % 6);
      cfg_dst_leaf = 5'($urandom);
      cfg_dst_port = 4'($urandom);
      credit_upd   = ($urandom % 16) == 0;
      credit_port  = 4'($urandom % 6);
      out_stall    = ($urandom % 5) == 0;
      step();
      n_assert++; if (ack_got !== ack_exp || pkt_got !== pkt_exp) begin n_fail++; $display("FAIL random i=%0d ack=%b/%b pkt=%h/%h (got/exp)", i, ack_got, ack_exp, pkt_got, pkt_exp); end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_rotation();
    test_unconfigured();
    test_credit();
    test_addr_wrap();
    test_stall();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
